// File: rtl/alu_arb.sv
// alu_arb -- two-requester arbiter in front of one shared 8-bit ALU.
//
// Purpose:
//   Picks one of two requesters in IDLE and latches its opcode, operands
//   and shift amount into registered ALU drive lines. It then gives the
//   external ALU LAT cycles to settle, captures the result and flags, and
//   pulses done to the requester that was granted.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   req0/req1                 operation requests
//   op*/a*/b*/shamt*          per-requester opcode, operands, shift amount
//   gnt0/gnt1                 one-cycle grant pulse
//   done0/done1               one-cycle completion pulse
//   res, res_flags            captured ALU result and flags
//   busy                      operation in flight (EXEC or DONE)
//   alu_a/alu_b/alu_op/alu_shamt  registered drive to the shared ALU
//   alu_out, alu_flags        shared ALU outputs
//
// Configuration:
//   ALU_ARB_RR_EN  defined   -> round-robin on a tie, using a last-winner pointer
//                  undefined -> req0 always wins a tie, and there is no pointer
//
// Parameter LAT (1..4) is the number of EXEC cycles before capture.

module alu_arb #(
  parameter int LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] op0,
  input  logic [3:0] op1,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  input  logic [2:0] shamt0,
  input  logic [2:0] shamt1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] res,
  output logic [3:0] res_flags,
  output logic       busy,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_op,
  output logic [2:0] alu_shamt,
  input  logic [7:0] alu_out,
  input  logic [3:0] alu_flags
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] CNT_INIT = 2'(LAT - 1);

  state_t     r_state, w_next;
  logic [1:0] r_cnt;
  logic       r_who;        // requester that owns the operation in flight
  logic       r_gnt0, r_gnt1, r_done0, r_done1;
  logic [7:0] r_res, r_a, r_b;
  logic [3:0] r_flags, r_op;
  logic [2:0] r_shamt;
  logic       w_issue, w_capture, w_win1;

`ifdef ALU_ARB_RR_EN
  // The pointer resets to 1, so requester 0 wins the first tie.
  logic r_last;
  assign w_win1 = req1 & (~req0 | ~r_last);

  always_ff @(posedge clk) begin
    if (rst)          r_last <= 1'b1;
    else if (w_issue) r_last <= w_win1;
  end
`else
  assign w_win1 = req1 & ~req0;
`endif

  always_comb begin
    w_next    = r_state;
    w_issue   = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      S_IDLE: if (req0 | req1) begin
        w_next  = S_EXEC;
        w_issue = 1'b1;
      end
      S_EXEC: if (r_cnt == 2'd0) begin
        w_next    = S_DONE;
        w_capture = 1'b1;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
      r_who   <= 1'b0;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_res   <= 8'd0;
      r_flags <= 4'd0;
      r_a     <= 8'd0;
      r_b     <= 8'd0;
      r_op    <= 4'd0;
      r_shamt <= 3'd0;
    end else begin
      r_state <= w_next;
      r_gnt0  <= w_issue & ~w_win1;
      r_gnt1  <= w_issue & w_win1;
      r_done0 <= w_capture & ~r_who;
      r_done1 <= w_capture & r_who;
      if (w_issue) begin
        // Operands are taken only here, so later changes on the request
        // side cannot disturb the operation in flight.
        r_who   <= w_win1;
        r_cnt   <= CNT_INIT;
        r_a     <= w_win1 ? a1 : a0;
        r_b     <= w_win1 ? b1 : b0;
        r_op    <= w_win1 ? op1 : op0;
        r_shamt <= w_win1 ? shamt1 : shamt0;
      end else if (r_state == S_EXEC && r_cnt != 2'd0) begin
        r_cnt <= r_cnt - 2'd1;
      end
      if (w_capture) begin
        r_res   <= alu_out;
        r_flags <= alu_flags;
      end
    end
  end

  assign gnt0      = r_gnt0;
  assign gnt1      = r_gnt1;
  assign done0     = r_done0;
  assign done1     = r_done1;
  assign res       = r_res;
  assign res_flags = r_flags;
  assign busy      = (r_state == S_EXEC) || (r_state == S_DONE);
  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_op    = r_op;
  assign alu_shamt = r_shamt;

endmodule

// File: tb/tb_alu_arb.sv
// Bench for alu_arb: a LAT=1 instance (u1) and a LAT=3 instance (u3),
// each driving a small behavioural ALU. Expected completions are queued
// when stimulus is issued. A negedge monitor checks them against done pulses.
module tb_alu_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic       who;
    logic [7:0] res;
    logic [3:0] fl;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];

  // ALU model: {out, zero, neg, carry, valid}
  function automatic logic [11:0] alu_model(input logic [3:0] op, input logic [7:0] a,
                                            input logic [7:0] b, input logic [2:0] sh);
    logic [8:0] s;
    logic [7:0] o;
    logic       c;
    c = 1'b0;
    case (op)
      4'h1: begin s = {1'b0, a} + {1'b0, b}; o = s[7:0]; c = s[8]; end
      4'h2: o = a << sh;
      4'h3: o = a ^ b;
      default: o = a & b;
    endcase
    return {o, (o == 8'd0), o[7], c, 1'b1};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- instance u1 (LAT=1) ----------------
  logic       rst1, req0_1, req1_1, gnt0_1, gnt1_1, done0_1, done1_1, busy1;
  logic [3:0] op0_1, op1_1, fl1, aop1, aflags1;
  logic [7:0] a0_1, b0_1, a1_1, b1_1, res1, aa1, ab1, aout1;
  logic [2:0] sh0_1, sh1_1, ash1;
  assign {aout1, aflags1} = alu_model(aop1, aa1, ab1, ash1);

  alu_arb #(.LAT(1)) u1 (
    .clk(clk), .rst(rst1), .req0(req0_1), .req1(req1_1),
    .op0(op0_1), .op1(op1_1), .a0(a0_1), .b0(b0_1), .a1(a1_1), .b1(b1_1),
    .shamt0(sh0_1), .shamt1(sh1_1), .gnt0(gnt0_1), .gnt1(gnt1_1),
    .done0(done0_1), .done1(done1_1), .res(res1), .res_flags(fl1), .busy(busy1),
    .alu_a(aa1), .alu_b(ab1), .alu_op(aop1), .alu_shamt(ash1),
    .alu_out(aout1), .alu_flags(aflags1)
  );

  // ---------------- instance u3 (LAT=3) ----------------
  logic       rst3, req0_3, req1_3, gnt0_3, gnt1_3, done0_3, done1_3, busy3;
  logic [3:0] op0_3, op1_3, fl3, aop3, aflags3;
  logic [7:0] a0_3, b0_3, a1_3, b1_3, res3, aa3, ab3, aout3;
  logic [2:0] sh0_3, sh1_3, ash3;
  assign {aout3, aflags3} = alu_model(aop3, aa3, ab3, ash3);

  alu_arb #(.LAT(3)) u3 (
    .clk(clk), .rst(rst3), .req0(req0_3), .req1(req1_3),
    .op0(op0_3), .op1(op1_3), .a0(a0_3), .b0(b0_3), .a1(a1_3), .b1(b1_3),
    .shamt0(sh0_3), .shamt1(sh1_3), .gnt0(gnt0_3), .gnt1(gnt1_3),
    .done0(done0_3), .done1(done1_3), .res(res3), .res_flags(fl3), .busy(busy3),
    .alu_a(aa3), .alu_b(ab3), .alu_op(aop3), .alu_shamt(ash3),
    .alu_out(aout3), .alu_flags(aflags3)
  );

  // ---------------- monitor ----------------
  int l1 = 0;
  int l3 = 0;
  always @(negedge clk) begin
    exp_t e;
    if (gnt0_1 | gnt1_1) begin chk("gnt_excl_u1", gnt0_1 & gnt1_1, 0); l1 = 0; end
    else l1++;
    if (done0_1 | done1_1) begin
      chk("done_excl_u1", done0_1 & done1_1, 0);
      chk("latency_u1", l1, 1);
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_done_u1 actual=done expected=none");
      end else begin
        e = q1.pop_front();
        chk("done_who_u1", done1_1, e.who);
        chk("res_u1", res1, e.res);
        chk("flags_u1", fl1, e.fl);
      end
    end
    if (gnt0_3 | gnt1_3) begin chk("gnt_excl_u3", gnt0_3 & gnt1_3, 0); l3 = 0; end
    else l3++;
    if (done0_3 | done1_3) begin
      chk("done_excl_u3", done0_3 & done1_3, 0);
      chk("latency_u3", l3, 3);
      if (q3.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_done_u3 actual=done expected=none");
      end else begin
        e = q3.pop_front();
        chk("done_who_u3", done1_3, e.who);
        chk("res_u3", res3, e.res);
        chk("flags_u3", fl3, e.fl);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_gnt1(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!(gnt0_1 | gnt1_1) && n < 20);
    if (!(gnt0_1 | gnt1_1)) begin checks++; failures++; $display("FAIL gnt_timeout_u1 actual=none expected=gnt"); end
  endtask

  task automatic wait_idle1();
    int n;
    n = 0;
    while (busy1 && n < 20) begin @(negedge clk); n++; end
    chk("idle_timeout_u1", busy1, 0);
  endtask

  task automatic issue1(input logic who, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] sh, input logic [7:0] er, input logic [3:0] ef, input bit perturb);
    int n;
    exp_t e;
    e = '{who, er, ef};
    q1.push_back(e);
    if (!who) begin op0_1 = op; a0_1 = a; b0_1 = b; sh0_1 = sh; req0_1 = 1'b1; end
    else      begin op1_1 = op; a1_1 = a; b1_1 = b; sh1_1 = sh; req1_1 = 1'b1; end
    wait_gnt1(n);
    chk("gnt_delay_u1", n, 1);
    chk("gnt_who_u1", gnt1_1, who);
    chk("alu_a_u1", aa1, a);
    chk("alu_op_u1", aop1, op);
    req0_1 = 1'b0; req1_1 = 1'b0;
    if (perturb) begin
      a0_1 = 8'hFF;
      @(negedge clk);
      chk("alu_a_hold_u1", aa1, a);
    end
    wait_idle1();
    repeat (2) @(negedge clk);
    chk("res_hold_u1", res1, er);
  endtask

  initial begin
    int n;
    logic [3:0] exp_who;
    rst1 = 1'b1; rst3 = 1'b1;
    {req0_1, req1_1, req0_3, req1_3} = '0;
    {op0_1, op1_1, op0_3, op1_3} = '0;
    {a0_1, b0_1, a1_1, b1_1, a0_3, b0_3, a1_3, b1_3} = '0;
    {sh0_1, sh1_1, sh0_3, sh1_3} = '0;
    repeat (2) @(negedge clk);
    rst1 = 1'b0; rst3 = 1'b0;

    // reset state
    chk("rst_gnt_u1", {gnt0_1, gnt1_1, done0_1, done1_1, busy1}, 0);
    chk("rst_res_u1", {res1, fl1}, 0);
    chk("rst_alu_u1", {aa1, ab1, aop1, ash1}, 0);
    chk("rst_busy_u3", {busy3, res3, aa3}, 0);

    // directed vectors on the LAT=1 instance
    issue1(1'b0, 4'h1, 8'h3C, 8'h0F, 3'd2, 8'h4B, 4'b0001, 1'b1);
    issue1(1'b1, 4'h1, 8'hFF, 8'h01, 3'd0, 8'h00, 4'b1011, 1'b0);
    issue1(1'b0, 4'h2, 8'h81, 8'h00, 3'd3, 8'h08, 4'b0001, 1'b0);
    issue1(1'b1, 4'h3, 8'hA5, 8'h5A, 3'd0, 8'hFF, 4'b0101, 1'b0);
    issue1(1'b0, 4'h0, 8'hF0, 8'h3C, 3'd0, 8'h30, 4'b0001, 1'b0);

    // tie: both requesters held high after a fresh reset
    rst1 = 1'b1; @(negedge clk); rst1 = 1'b0;
`ifdef ALU_ARB_RR_EN
    exp_who = 4'b1010;
`else
    exp_who = 4'b0000;
`endif
    op0_1 = 4'h3; a0_1 = 8'h0F; b0_1 = 8'hF0; sh0_1 = 3'd0;
    op1_1 = 4'h3; a1_1 = 8'h0F; b1_1 = 8'hF0; sh1_1 = 3'd0;
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      e = '{exp_who[k], 8'hFF, 4'b0101};
      q1.push_back(e);
    end
    req0_1 = 1'b1; req1_1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_gnt1(n);
      chk("tie_who_u1", gnt1_1, exp_who[k]);
      chk("tie_interval_u1", n, (k == 0) ? 1 : 3);
    end
    req0_1 = 1'b0; req1_1 = 1'b0;
    wait_idle1();
    repeat (2) @(negedge clk);

    // LAT=3: single req1, latency and busy length
    begin
      exp_t e;
      e = '{1'b1, 8'h30, 4'b0001};
      q3.push_back(e);
    end
    op1_3 = 4'h1; a1_3 = 8'h10; b1_3 = 8'h20; req1_3 = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!gnt1_3 && n < 20);
    chk("gnt1_u3", gnt1_3, 1);
    req1_3 = 1'b0;
    n = 0;
    while (busy3 && n < 20) begin n++; @(negedge clk); end
    chk("busy_len_u3", n, 4);
    repeat (2) @(negedge clk);

    // LAT=3: reset in the second EXEC cycle aborts the operation
    op0_3 = 4'h1; a0_3 = 8'h01; b0_3 = 8'h02; sh0_3 = 3'd5; req0_3 = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!gnt0_3 && n < 20);
    chk("gnt0_u3", gnt0_3, 1);
    req0_3 = 1'b0;
    @(negedge clk);
    rst3 = 1'b1;
    @(negedge clk);
    rst3 = 1'b0;
    chk("abort_busy_u3", busy3, 0);
    chk("abort_res_u3", {res3, fl3}, 0);
    chk("abort_alu_u3", {aa3, ab3, aop3, ash3}, 0);
    repeat (6) @(negedge clk);

    chk("q1_drained", q1.size(), 0);
    chk("q3_drained", q3.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 Parameter LAT, default 1, number of EXEC cycles the shared 8-bit ALU is given to settle before capture; legal range 1..4.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0, req1  input  1 each  operation request from requester 0 / 1; held high with operands stable until the matching grant.
REQ-005 op0, op1  input  4 each  ALU opcode for requester 0 / 1.
REQ-006 a0, b0, a1, b1  input  8 each  operands for requester 0 / 1.
REQ-007 shamt0, shamt1  input  3 each  shift amount for requester 0 / 1.
REQ-008 gnt0, gnt1  output  1 each  one-cycle grant pulse; operands sampled on that edge.
REQ-009 done0, done1  output  1 each  one-cycle completion pulse to the granted requester.
REQ-010 res  output  8  captured ALU result.
REQ-011 res_flags  output  4  captured ALU flags.
REQ-012 busy  output  1  high in EXEC and DONE.
REQ-013 alu_a, alu_b  output  8 each; alu_op  output  4; alu_shamt  output  3: registered drive to the shared ALU.
REQ-014 alu_out  input  8; alu_flags  input  4: shared ALU outputs.

Function
REQ-015 States SHALL be IDLE, EXEC and DONE, encoded in 2 bits.
REQ-016 IDLE: with any req high at the edge, latch the winner's op/a/b/shamt into alu_*, pulse its gnt for the next cycle, load the counter with LAT-1 and go to EXEC; with no req, stay in IDLE.
REQ-017 EXEC: alu_* SHALL hold the latched values; the counter decrements each cycle.
REQ-018 EXEC exit: at the edge where the counter is 0, capture alu_out into res and alu_flags into res_flags, then go to DONE.
REQ-019 DONE: assert done of the granted requester for exactly one cycle, then go to IDLE.
REQ-020 Requests SHALL be sampled only in IDLE; a request arriving in EXEC or DONE waits.
REQ-021 Latency: done SHALL rise exactly LAT cycles after gnt rises; back-to-back issue interval is LAT+2 cycles.
REQ-022 res and res_flags SHALL hold their value until the next capture.
REQ-023 Deasserting req or changing operands after the grant SHALL NOT affect the operation in flight.
REQ-024 gnt0/gnt1 SHALL never both be high; done0/done1 SHALL never both be high.
REQ-025 A 1-bit last-winner pointer SHALL update on every grant.

Reset
REQ-026 With rst high at an edge: state goes to IDLE, the pointer is set to 1 so requester 0 wins the first tie, and the counter is cleared.
REQ-027 The same reset edge SHALL clear gnt*, done*, busy, res, res_flags and alu_* to 0.
REQ-028 Reset during EXEC or DONE SHALL abort the operation; no done pulse follows.

Configuration
REQ-029 Macro ALU_ARB_RR_EN defined: on a tie, the requester that was not the last winner wins (round-robin).
REQ-030 Macro ALU_ARB_RR_EN undefined: req0 always wins a tie (fixed priority); the pointer is not implemented.

Verification
REQ-031 LAT=1; req0 with a0=8'h3C, b0=8'h0F, op0=4'h1, shamt0=3'd2; ALU model returns 8'h4B / 4'b0001 -> gnt0 in cycle 1, alu_a=8'h3C, done0 in cycle 2, res=8'h4B, res_flags=4'b0001.
REQ-032 LAT=3; a single req1 -> done1 exactly 3 cycles after gnt1; busy high for 4 cycles.
REQ-033 RR_EN defined; req0 and req1 held high continuously -> grants alternate 0,1,0,1 (gnt0 first after reset), one issue every LAT+2 cycles.
REQ-034 RR_EN undefined; req0 and req1 held high -> only gnt0 pulses; req1 is starved.
REQ-035 rst asserted in the second EXEC cycle with LAT=3 -> no done pulse; next cycle busy=0, res=8'h00, alu_*=0.
REQ-036 req0 dropped and a0 changed to 8'hFF the cycle after gnt0 -> alu_a keeps its latched value and done0 still pulses.
